ssd_scan_driver: RTL and testbench

//  Parametrised multiplexed 7-segment driver for DIGITS common-anode digits.

---
 rtl/ssd_pkg.sv | 39 +++
 rtl/ssd_bin2bcd.sv | 63 ++++++
 rtl/ssd_scan_driver.sv | 171 +++++++++++++++++
 tb/tb_ssd_scan_driver.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan driver.
// Segment vectors are active-low {a,b,c,d,e,f,g}.
package ssd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  // Ceiling log2, never less than 1 so it can size a counter directly.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic logic [6:0] seg_font(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ssd_bin2bcd.sv
// Iterative double-dabble converter: one add-3/shift step per clock, VAL_W steps.
// The first step is folded into the start cycle, so done rises VAL_W-1 cycles after start.
module ssd_bin2bcd #(
  parameter int DIGITS = 4,
  parameter int VAL_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [VAL_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);
  import ssd_pkg::*;

  localparam int BCD_W  = 4 * (DIGITS + 1);
  localparam int STEP_W = clog2_min1(VAL_W + 1);

  logic [BCD_W-1:0]  r_bcd;
  logic [VAL_W-1:0]  r_bin;
  logic [STEP_W-1:0] r_step;
  logic              r_busy;
  logic              r_done;
  logic [BCD_W-1:0]  w_adj;

  for (genvar gi = 0; gi < DIGITS + 1; gi++) begin : g_adj
    assign w_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ? r_bcd[4*gi +: 4] + 4'd3
                                                          : r_bcd[4*gi +: 4];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bcd  <= '0;
      r_bin  <= '0;
      r_step <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (start) begin
      // Register starts at zero, so the first add-3 pass is a no-op.
      r_bcd  <= {{(BCD_W-1){1'b0}}, bin[VAL_W-1]};
      r_bin  <= bin << 1;
      r_step <= STEP_W'(1);
      r_busy <= 1'b1;
      r_done <= (VAL_W == 1);
    end else if (r_busy && !r_done) begin
      r_bcd  <= {w_adj[BCD_W-2:0], r_bin[VAL_W-1]};
      r_bin  <= r_bin << 1;
      r_step <= r_step + STEP_W'(1);
      r_done <= (r_step == STEP_W'(VAL_W - 1));
    end else if (r_done) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd[4*DIGITS-1:0];
  assign ovf  = |r_bcd[BCD_W-1 -: 4];

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed common-anode 7-segment driver: captures a value, converts it (hex or decimal),
// commits it atomically and scans the digits MSD first with a dead time at each slot start.
module ssd_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int VAL_W       = 14,
  parameter int REFRESH_CYC = 262144,
  parameter int DEAD_CYC    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [VAL_W-1:0]  value,
  input  logic              load,
  input  logic              hex_mode,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] dp_en,
  output logic              busy,
  output logic [DIGITS-1:0] anode,
  output logic [6:0]        seg,
  output logic              dp_n
);
  import ssd_pkg::*;

  localparam int CNT_W = clog2_min1(REFRESH_CYC);
  localparam int IDX_W = clog2_min1(DIGITS);
  localparam int EXT_W = (VAL_W > 4*DIGITS) ? VAL_W : 4*DIGITS;

  logic [VAL_W-1:0]          r_cap_val;
  logic                      r_cap_hex;
  logic                      r_cap_blz;
  logic [DIGITS-1:0]         r_cap_dp;
  logic                      r_start;

  logic [DIGITS-1:0][3:0]    r_dig;
  logic [DIGITS-1:0]         r_blank;
  logic [DIGITS-1:0]         r_dp;
  logic                      r_ovf;

  logic [CNT_W-1:0]          r_cnt;
  logic [IDX_W-1:0]          r_idx;
  logic [DIGITS-1:0]         r_anode;
  logic [6:0]                r_seg;
  logic                      r_dp_n;

  logic                      w_busy;
  logic                      w_done;
  logic                      w_accept;
  logic [4*DIGITS-1:0]       w_bcd;
  logic                      w_dec_ovf;
  logic [DIGITS-1:0][3:0]    w_dec_dig;
  logic [DIGITS-1:0][3:0]    w_hex_dig;
  logic [EXT_W-1:0]          w_hex_ext;
  logic                      w_hex_ovf;
  logic [DIGITS-1:0]         w_lz;
  logic                      w_run;
  logic                      w_commit;
  logic                      w_dead;
  logic [3:0]                w_sel_dig;
  logic [6:0]                w_sel_seg;

  assign w_accept = load && !w_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cap_val <= '0;
      r_cap_hex <= 1'b0;
      r_cap_blz <= 1'b0;
      r_cap_dp  <= '0;
      r_start   <= 1'b0;
    end else begin
      r_start <= w_accept;
      if (w_accept) begin
        r_cap_val <= value;
        r_cap_hex <= hex_mode;
        r_cap_blz <= blank_lz;
        r_cap_dp  <= dp_en;
      end
    end
  end

  ssd_bin2bcd #(
    .DIGITS (DIGITS),
    .VAL_W  (VAL_W)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (r_start && !r_cap_hex),
    .bin   (r_cap_val),
    .busy  (w_busy),
    .done  (w_done),
    .bcd   (w_bcd),
    .ovf   (w_dec_ovf)
  );

  assign w_hex_ext = EXT_W'(r_cap_val);

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
    assign w_hex_dig[gi] = w_hex_ext[4*gi +: 4];
    assign w_dec_dig[gi] = w_bcd[4*gi +: 4];
  end

  if (VAL_W > 4*DIGITS) begin : g_hex_ovf
    assign w_hex_ovf = |r_cap_val[VAL_W-1:4*DIGITS];
  end else begin : g_no_hex_ovf
    assign w_hex_ovf = 1'b0;
  end

  // Leading-zero mask walks down from the MSD; the LSD always stays visible.
  always_comb begin
    w_run = 1'b1;
    w_lz  = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_run   = w_run && (w_dec_dig[i] == 4'd0);
      w_lz[i] = w_run;
    end
  end

  assign w_commit = (r_start && r_cap_hex) || w_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dig   <= '0;
      r_blank <= '0;
      r_dp    <= '0;
      r_ovf   <= 1'b0;
    end else if (w_commit) begin
      r_dig   <= r_cap_hex ? w_hex_dig : w_dec_dig;
      r_blank <= (!r_cap_hex && r_cap_blz) ? w_lz : '0;
      r_dp    <= r_cap_dp;
      r_ovf   <= r_cap_hex ? w_hex_ovf : w_dec_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= IDX_W'(DIGITS - 1);
    end else if (r_cnt == CNT_W'(REFRESH_CYC - 1)) begin
      r_cnt <= '0;
      r_idx <= (r_idx == '0) ? IDX_W'(DIGITS - 1) : r_idx - IDX_W'(1);
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_dead    = (r_cnt < CNT_W'(DEAD_CYC));
  assign w_sel_dig = r_dig[r_idx];
  assign w_sel_seg = r_ovf          ? SEG_DASH  :
                     r_blank[r_idx] ? SEG_BLANK : seg_font(w_sel_dig);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_anode <= '1;
      r_seg   <= SEG_BLANK;
      r_dp_n  <= 1'b1;
    end else if (w_dead) begin
      r_anode <= '1;
      r_seg   <= SEG_BLANK;
      r_dp_n  <= 1'b1;
    end else begin
      r_anode <= ~(DIGITS'(1) << r_idx);
      r_seg   <= w_sel_seg;
      r_dp_n  <= ~r_dp[r_idx];
    end
  end

  assign busy  = w_busy;
  assign anode = r_anode;
  assign seg   = r_seg;
  assign dp_n  = r_dp_n;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench: table vectors, hand-written corner sequences and random loads,
// all judged by an arithmetic model of the display contents and the scan timing.
module tb_ssd_scan_driver;
  localparam int D  = 4;
  localparam int VW = 14;
  localparam int RC = 8;
  localparam int DC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [VW-1:0] value = '0;
  logic          load = 1'b0;
  logic          hex_mode = 1'b0;
  logic          blank_lz = 1'b0;
  logic [D-1:0]  dp_en = '0;
  logic          busy;
  logic [D-1:0]  anode;
  logic [6:0]    seg;
  logic          dp_n;

  ssd_scan_driver #(
    .DIGITS      (D),
    .VAL_W       (VW),
    .REFRESH_CYC (RC),
    .DEAD_CYC    (DC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value    (value),
    .load     (load),
    .hex_mode (hex_mode),
    .blank_lz (blank_lz),
    .dp_en    (dp_en),
    .busy     (busy),
    .anode    (anode),
    .seg      (seg),
    .dp_n     (dp_n)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Edges seen with reset released; output after edge n reflects scan position n-1.
  int unsigned tick = 0;
  always @(posedge clk) tick <= rst_n ? tick + 1 : 0;

  logic [D-1:0][6:0] m_seg;
  logic [D-1:0]      m_dp;

  typedef struct {
    int               v;
    bit               hex;
    bit               blz;
    logic [D-1:0]     dp;
    logic [D-1:0][6:0] exp;
  } vec_t;

  function automatic logic [6:0] font(input int n);
    logic [6:0] tbl [16];
    tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    return tbl[n];
  endfunction

  function automatic logic [D-1:0][6:0] ref_disp(input int v, input bit hex, input bit blz);
    logic [D-1:0][6:0] e;
    int p;
    int lim;
    lim = 1;
    for (int i = 0; i < D; i++) lim = lim * 10;
    p = 1;
    for (int i = 0; i < D; i++) begin
      if (hex) e[i] = font((v >> (4*i)) & 15);
      else if (v >= lim) e[i] = 7'b1111110;
      else if (blz && i > 0 && v < p) e[i] = 7'b1111111;
      else e[i] = font((v / p) % 10);
      p = p * 10;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  task automatic check_out();
    logic [11:0]  e;
    logic [D-1:0] one;
    int j;
    int c;
    int idx;
    one = 1;
    if (tick == 0) begin
      e = {4'hF, 7'h7F, 1'b1};
    end else begin
      j   = int'(tick) - 1;
      c   = j % RC;
      idx = D - 1 - ((j / RC) % D);
      if (c < DC) e = {4'hF, 7'h7F, 1'b1};
      else        e = {~(one << idx), m_seg[idx], ~m_dp[idx]};
    end
    check("scan{anode,seg,dp_n}", {20'd0, anode, seg, dp_n}, {20'd0, e});
  endtask

  task automatic tic();
    @(negedge clk);
    check_out();
  endtask

  task automatic start_load(input int v, input bit hex, input bit blz, input logic [D-1:0] dp);
    value    = VW'(v);
    hex_mode = hex;
    blank_lz = blz;
    dp_en    = dp;
    load     = 1'b1;
    tic();
    load = 1'b0;
    check("busy_after_capture", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_busy(input string name, input int exp_n);
    int n;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      tic();
      if (!busy) break;
      n++;
    end
    check(name, n, exp_n);
  endtask

  task automatic apply(input vec_t t);
    start_load(t.v, t.hex, t.blz, t.dp);
    if (t.hex) begin
      tic();
      check("busy_hex", {31'd0, busy}, 32'd0);
    end else begin
      wait_busy("busy_len", VW);
    end
    m_seg = t.exp;
    m_dp  = t.dp;
    repeat (RC*D + 4) tic();
  endtask

  vec_t tbl [8];
  vec_t rv;
  int   n;

  initial begin
    tbl[0] = '{1234,  0, 0, 4'b0000, {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}};
    tbl[1] = '{7,     0, 1, 4'b0000, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0001111}};
    tbl[2] = '{7,     0, 0, 4'b0000, {7'b0000001, 7'b0000001, 7'b0000001, 7'b0001111}};
    tbl[3] = '{12345, 0, 0, 4'b0010, {4{7'b1111110}}};
    tbl[4] = '{14'h3ABC, 1, 1, 4'b0000, {7'b0000110, 7'b0001000, 7'b1100000, 7'b0110001}};
    tbl[5] = '{0,     0, 1, 4'b0001, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}};
    tbl[6] = '{9999,  0, 0, 4'b0101, {4{7'b0000100}}};
    tbl[7] = '{100,   0, 1, 4'b1000, {7'b1111111, 7'b1001111, 7'b0000001, 7'b0000001}};

    m_seg = {D{7'b0000001}};
    m_dp  = '0;

    // Reset held 3 cycles, then a full scan of "0000".
    repeat (3) tic();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_anode", {28'd0, anode}, 32'hF);
    rst_n = 1'b1;
    repeat (RC*D + 8) tic();

    for (int i = 0; i < 8; i++) apply(tbl[i]);

    // Load while busy is dropped; load on the first busy-low cycle is taken.
    start_load(1234, 0, 0, 4'b0000);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      tic();
      if (!busy) break;
      n++;
      load  = (c == 3);
      value = (c == 3) ? VW'(9999) : VW'(1234);
    end
    load = 1'b0;
    check("busy_ignores_load", n, VW);
    m_seg = ref_disp(1234, 0, 0);
    m_dp  = '0;
    start_load(42, 0, 0, 4'b0000);
    wait_busy("busy_fall_load", VW);
    m_seg = ref_disp(42, 0, 0);
    repeat (RC*D + 4) tic();

    // Reset in the middle of a conversion aborts it without a commit.
    start_load(5555, 0, 0, 4'b1111);
    repeat (5) tic();
    rst_n = 1'b0;
    tic();
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_seg", {25'd0, seg}, 32'h7F);
    m_seg = {D{7'b0000001}};
    m_dp  = '0;
    rst_n = 1'b1;
    repeat (RC*D + 20) tic();

    for (int r = 0; r < 20; r++) begin
      rv.v   = int'($urandom_range(0, 16383));
      rv.hex = 1'($urandom_range(0, 1));
      rv.blz = 1'($urandom_range(0, 1));
      rv.dp  = D'($urandom_range(0, 15));
      rv.exp = ref_disp(rv.v, rv.hex, rv.blz);
      apply(rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
